// File: rtl/dco.sv
// dco: phase-accumulator digitally controlled oscillator with deferred control update and period measurement
//   clk          : single clock, rising edge
//   rst_n        : asynchronous active-low reset
//   enable       : run enable (0 = IDLE, 1 = RUN)
//   ctrl_word    : frequency control word from the loop filter
//   ctrl_valid   : ctrl_word valid this cycle
//   dco_out      : oscillator output (accumulator MSB)
//   dco_edge     : one-cycle pulse when dco_out first reads 1
//   ctrl_applied : one-cycle pulse when a new increment takes effect
//   period_count : clk cycles between the last two dco_edge pulses
//   period_valid : one-cycle pulse when period_count updates
module dco #(
    parameter int                   WIDTH       = 20,
    parameter int                   ACC_WIDTH   = 24,
    parameter logic [ACC_WIDTH-1:0] CENTER_WORD = 24'h008000,
    parameter int                   GAIN_SHIFT  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] ctrl_word,
    input  logic             ctrl_valid,
    output logic             dco_out,
    output logic             dco_edge,
    output logic             ctrl_applied,
    output logic [15:0]      period_count,
    output logic             period_valid
);
    // ARM: running but no edge seen yet, so the first edge only restarts the count
    typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

    localparam logic [ACC_WIDTH:0] INC_MAX = {2'b00, {(ACC_WIDTH-1){1'b1}}};

    state_t               state, state_next;
    logic [ACC_WIDTH-1:0] acc, inc, acc_sum, inc_next;
    logic [ACC_WIDTH:0]   inc_sum;
    logic [WIDTH-1:0]     pend_word, src_word;
    logic                 pend_flag, rise, edge_now, apply;
    logic [15:0]          cnt, cnt_sat;
    logic [16:0]          cnt_inc;

    assign dco_out = acc[ACC_WIDTH-1];

    always_comb begin
        acc_sum  = acc + inc;
        rise     = acc_sum[ACC_WIDTH-1] & ~acc[ACC_WIDTH-1];
        edge_now = enable & rise;
        // a same-cycle control word bypasses the pending register
        src_word = ctrl_valid ? ctrl_word : pend_word;
        apply    = edge_now & (ctrl_valid | pend_flag);
        inc_sum  = {1'b0, CENTER_WORD} + (ACC_WIDTH+1)'(src_word >> GAIN_SHIFT);
        inc_next = inc_sum > INC_MAX ? INC_MAX[ACC_WIDTH-1:0] : inc_sum[ACC_WIDTH-1:0];
        cnt_inc  = {1'b0, cnt} + 17'd1;
        cnt_sat  = cnt_inc[16] ? 16'hFFFF : cnt_inc[15:0];
        state_next = !enable ? IDLE : (edge_now || state == RUN) ? RUN : ARM;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc          <= '0;
            inc          <= CENTER_WORD;
            pend_word    <= '0;
            pend_flag    <= 1'b0;
            dco_edge     <= 1'b0;
            ctrl_applied <= 1'b0;
            period_valid <= 1'b0;
            period_count <= '0;
            cnt          <= '0;
        end else begin
            if (apply) begin
                inc       <= inc_next;
                pend_flag <= 1'b0;
            end else if (ctrl_valid) begin
                pend_word <= ctrl_word;
                pend_flag <= 1'b1;
            end
            if (!enable) begin
                acc          <= '0;
                dco_edge     <= 1'b0;
                ctrl_applied <= 1'b0;
                period_valid <= 1'b0;
                cnt          <= '0;
            end else begin
                acc          <= acc_sum;
                dco_edge     <= rise;
                ctrl_applied <= apply;
                period_valid <= rise && state == RUN;
                if (rise && state == RUN) period_count <= cnt_sat;
                // cnt holds the non-edge updates since the last edge; the period includes the edge cycle
                cnt <= rise ? 16'd0 : cnt_sat;
            end
        end
    end
endmodule

// File: tb/tb_dco.sv
// tb_dco: self-checking bench for dco (default instance plus a saturating-increment instance)
module tb_dco;
    typedef struct {
        logic [19:0] word;
        int          lo;
        int          hi;
    } vec_t;

    typedef struct {
        int lo;
        int hi;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, enable, ctrl_valid;
    logic [19:0] ctrl_word;
    logic        dco_out, dco_edge, ctrl_applied, period_valid;
    logic [15:0] period_count;

    logic        s_rst_n, s_en, s_valid;
    logic [19:0] s_ctrl;
    logic        s_out, s_edge, s_app, s_pv;
    logic [15:0] s_pc;

    int   n_vec  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    dco u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .ctrl_word(ctrl_word), .ctrl_valid(ctrl_valid),
        .dco_out(dco_out), .dco_edge(dco_edge), .ctrl_applied(ctrl_applied),
        .period_count(period_count), .period_valid(period_valid)
    );

    dco #(.CENTER_WORD(24'h7FFFF0)) u_sat (
        .clk(clk), .rst_n(s_rst_n), .enable(s_en), .ctrl_word(s_ctrl), .ctrl_valid(s_valid),
        .dco_out(s_out), .dco_edge(s_edge), .ctrl_applied(s_app),
        .period_count(s_pc), .period_valid(s_pv)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic logic sig(input int which);
        return which == 0 ? dco_edge : which == 1 ? period_valid : ctrl_applied;
    endfunction

    // waits (sampling on negedge) until the chosen output is high; n = clk edges consumed
    task automatic wait_for(input int which, input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (sig(which)) return;
        end
        n_vec++;
        n_fail++;
        $display("FAIL timeout waiting on output %0d after %0d cycles", which, budget);
    endtask

    task automatic pulse_ctrl(input logic [19:0] w);
        ctrl_word  = w;
        ctrl_valid = 1'b1;
        @(negedge clk);
        ctrl_valid = 1'b0;
    endtask

    task automatic check_period(input string name);
        int   n;
        exp_t e;
        wait_for(1, 2000, n);
        wait_for(1, 2000, n);
        e = sb.pop_front();
        chk_rng(name, int'(period_count), e.lo, e.hi);
    endtask

    initial begin
        vec_t  vecs[4];
        int    n;
        logic [23:0] m_acc, m_old, m_inc;
        logic [24:0] sat_sum;
        logic  m_pend, m_edge;

        vecs[0] = '{20'h80000, 256, 256};
        vecs[1] = '{20'hFFFFF, 170, 171};
        vecs[2] = '{20'h40000, 341, 342};
        vecs[3] = '{20'h00000, 512, 512};

        rst_n = 1'b0; enable = 1'b0; ctrl_valid = 1'b0; ctrl_word = '0;
        s_rst_n = 1'b0; s_en = 1'b0; s_valid = 1'b0; s_ctrl = '0;
        repeat (3) @(negedge clk);
        chk("reset flags", int'({dco_out, dco_edge, ctrl_applied, period_valid}), 0);
        chk("reset period_count", int'(period_count), 0);

        // free run
        rst_n = 1'b1; enable = 1'b1;
        wait_for(0, 1000, n);
        chk("free first edge cycles", n, 256);
        chk("free first edge no period_valid", int'(period_valid), 0);
        @(negedge clk);
        chk("edge is one cycle", int'(dco_edge), 0);
        wait_for(1, 1000, n);
        chk("free period cycles", n + 1, 512);
        chk("free period_count", int'(period_count), 512);
        chk("free period edge coincident", int'(dco_edge), 1);
        wait_for(1, 1000, n);
        chk("free period_count 2", int'(period_count), 512);

        // control words applied mid-period
        foreach (vecs[i]) begin
            wait_for(0, 2000, n);
            repeat (20) @(negedge clk);
            pulse_ctrl(vecs[i].word);
            sb.push_back('{vecs[i].lo, vecs[i].hi});
            wait_for(2, 2000, n);
            chk("applied on edge", int'(dco_edge), 1);
            check_period("ctrl period");
        end

        // overwrite: only the later word takes effect
        wait_for(0, 2000, n);
        repeat (10) @(negedge clk);
        pulse_ctrl(20'h00000);
        repeat (10) @(negedge clk);
        pulse_ctrl(20'h80000);
        sb.push_back('{256, 256});
        wait_for(2, 2000, n);
        chk("overwrite applied on edge", int'(dco_edge), 1);
        check_period("overwrite period");

        // bypass: control word coincident with an edge-producing update
        wait_for(0, 2000, n);
        repeat (255) @(negedge clk);
        ctrl_word = 20'h00000; ctrl_valid = 1'b1;
        sb.push_back('{512, 512});
        @(negedge clk);
        ctrl_valid = 1'b0;
        chk("bypass edge", int'(dco_edge), 1);
        chk("bypass applied", int'(ctrl_applied), 1);
        wait_for(0, 2000, n);
        chk("bypass leaves pending clear", int'(ctrl_applied), 0);
        wait_for(1, 2000, n);
        n = sb.pop_front().lo;
        chk("bypass period", int'(period_count), n);

        // enable toggle mid-period
        wait_for(0, 2000, n);
        repeat (100) @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle flags", int'({dco_out, dco_edge, period_valid, ctrl_applied}), 0);
        end
        chk("idle keeps period_count", int'(period_count), 512);
        enable = 1'b1;
        wait_for(0, 1000, n);
        chk("re-enable first edge cycles", n, 256);
        chk("re-enable no period_valid", int'(period_valid), 0);

        // async reset discards pending word and restores CENTER_WORD
        wait_for(0, 2000, n);
        repeat (20) @(negedge clk);
        pulse_ctrl(20'h80000);
        wait_for(2, 2000, n);
        wait_for(0, 2000, n);
        repeat (20) @(negedge clk);
        pulse_ctrl(20'hFFFFF);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset flags", int'({dco_out, dco_edge, ctrl_applied, period_valid}), 0);
        chk("async reset period_count", int'(period_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_for(0, 1000, n);
        chk("post-reset first edge cycles", n, 256);
        chk("post-reset pending discarded", int'(ctrl_applied), 0);
        wait_for(1, 1000, n);
        chk("post-reset period", int'(period_count), 512);

        // saturation instance, checked against a cycle model
        sat_sum = 25'h7FFFF0 + 25'(20'hFFFFF >> 4);
        m_inc   = 24'h7FFFF0;
        m_acc   = '0;
        m_pend  = 1'b0;
        @(negedge clk);
        s_rst_n = 1'b1; s_en = 1'b1; s_ctrl = 20'hFFFFF; s_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            m_old  = m_acc;
            m_acc  = m_acc + m_inc;
            m_edge = m_acc[23] & ~m_old[23];
            if (m_edge && (s_valid || m_pend)) begin
                m_inc  = sat_sum > 25'h7FFFFF ? 24'h7FFFFF : sat_sum[23:0];
                m_pend = 1'b0;
            end else if (s_valid) m_pend = 1'b1;
            @(negedge clk);
            s_valid = 1'b0;
            chk("sat dco_out", int'(s_out), int'(m_acc[23]));
            chk("sat dco_edge", int'(s_edge), int'(m_edge));
            if (s_pv) chk_rng("sat period", int'(s_pc), 2, 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/dco.md
DCO -- requirements
Module: dco

Interface
REQ-001 SHALL have parameter WIDTH, default 20: control word width, matching the loop filter's dig_ctrl_voltage width.
REQ-002 SHALL have parameter ACC_WIDTH, default 24: phase accumulator width.
REQ-003 SHALL have parameter CENTER_WORD, default 24'h008000: free-running increment.
REQ-004 SHALL have parameter GAIN_SHIFT, default 4: right shift applied to the control word.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port enable, input, 1 bit: oscillator run enable.
REQ-008 SHALL have port ctrl_word, input, WIDTH bits: frequency control word from the loop filter.
REQ-009 SHALL have port ctrl_valid, input, 1 bit: ctrl_word is valid this cycle.
REQ-010 SHALL have port dco_out, output, 1 bit: oscillator output, equal to the accumulator MSB.
REQ-011 SHALL have port dco_edge, output, 1 bit: one-cycle pulse on a dco_out 0->1 transition.
REQ-012 SHALL have port ctrl_applied, output, 1 bit: one-cycle pulse when a new increment takes effect.
REQ-013 SHALL have port period_count, output, 16 bits: clk cycles between the last two dco_edge pulses.
REQ-014 SHALL have port period_valid, output, 1 bit: one-cycle pulse when period_count updates.

Function
REQ-015 SHALL implement two states: IDLE (enable=0) and RUN (enable=1). A state change SHALL take effect on the clk edge that samples the new enable value.
REQ-016 SHALL, in RUN, set acc <= acc + inc on each cycle, modulo 2^ACC_WIDTH (natural wrap, no saturation of acc).
REQ-017 SHALL compute a new increment as CENTER_WORD + (ctrl_word >> GAIN_SHIFT), zero-extended to ACC_WIDTH and saturated to 2^(ACC_WIDTH-1)-1.
REQ-018 SHALL register dco_out and dco_edge; dco_edge SHALL be high in exactly the cycle in which dco_out first reads 1.
REQ-019 SHALL store ctrl_word into a pending register on ctrl_valid=1, in any state; a later word SHALL overwrite an earlier unapplied one.
REQ-020 SHALL change inc only at a RUN update that produces dco_edge, using the pending word. ctrl_applied SHALL pulse in the same cycle as dco_edge. The pending flag SHALL then clear.
REQ-021 SHALL, when ctrl_valid coincides with an edge-producing update, apply that same-cycle ctrl_word immediately (bypass) and leave pending clear.
REQ-022 SHALL count clk cycles since the last dco_edge. At each dco_edge after the first one since entering RUN, it SHALL load period_count with that count, pulse period_valid and restart the count. The count SHALL saturate at 16'hFFFF.
REQ-023 SHALL, on the first dco_edge after entering RUN, restart the count without pulsing period_valid.
REQ-024 SHALL, in IDLE, clear acc, dco_out, dco_edge, ctrl_applied, period_valid and the cycle count; inc, pending and period_count SHALL be retained.
REQ-025 SHALL, on re-entering RUN, restart accumulation from acc=0.

Reset
REQ-026 SHALL, on rst_n=0, immediately set acc=0, inc=CENTER_WORD, pending clear, state IDLE, and all outputs to 0, including period_count=16'h0000.
REQ-027 SHALL, on rst_n deassertion, start state updates at the first rising clk edge with rst_n=1.
REQ-028 SHALL, when reset is asserted mid-period, discard any pending word and any partial period measurement.

Verification
REQ-029 SHALL cover free-run: reset release, enable=1, no ctrl -> first dco_edge on the 256th RUN cycle; then period_count=512 with period_valid every 512 cycles.
REQ-030 SHALL cover control update: ctrl_word=20'h80000 pulsed mid-period -> no change until the next dco_edge, where ctrl_applied=1; subsequent periods=256.
REQ-031 SHALL cover overwrite and bypass: two ctrl_valid pulses within one period (20'h00000, then 20'h80000) -> only 20'h80000 is applied. Separately, ctrl_valid coincident with dco_edge -> that word is applied at that edge.
REQ-032 SHALL cover enable toggle: enable=0 for 10 cycles mid-period -> dco_out=0 and no pulses; on re-enable the first edge occurs 256 cycles later (current inc 32768) with no period_valid on that edge.
REQ-033 SHALL cover async reset: rst_n low between clk edges after an applied 20'h80000 -> outputs clear immediately; after release and enable=1, the period returns to 512.
REQ-034 SHALL cover saturation: CENTER_WORD=24'h7FFFF0, ctrl_word=20'hFFFFF -> inc=24'h7FFFFF; dco_out toggles with a period of 2-3 cycles and period_count never reads 0.
